// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
// Ports: none (package only).
// Holds the fetch FSM state encoding, the queue entry layout and reset defaults.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN        = 32;
  localparam int unsigned FETCH_ENTRY_WIDTH = 2 * FETCH_XLEN;

  localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // One instruction-queue line: pc in the upper half, instruction below.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

  // Force word alignment of a fetch address.
  function automatic logic [FETCH_XLEN-1:0] align_pc(input logic [FETCH_XLEN-1:0] addr);
    return {addr[FETCH_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Purpose: sequential PC generation, single-outstanding ibus reads, {pc, inst} pushes into the decode queue.
// Latency: IDLE->REQ in 1 cycle; push is combinational on the ack cycle, so zero-wait throughput is 1 entry / 2 cycles.
// Backpressure: a new read is only issued while fifo_full is low; redirects flush the queue and drop in-flight data.
// Ports: clk/rst (sync, active-high); redirect_valid/redirect_pc from branch/exception logic;
//        ibus_req/ibus_addr/ibus_ack/ibus_rdata instruction bus; fifo_full/fifo_push/fifo_push_data/fifo_flush to the queue.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              ibus_req,
  output logic [XLEN-1:0]   ibus_addr,
  input  logic              ibus_ack,
  input  logic [XLEN-1:0]   ibus_rdata,
  input  logic              fifo_full,
  output logic              fifo_push,
  output logic [2*XLEN-1:0] fifo_push_data,
  output logic              fifo_flush
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] redirect_aligned;

  // Masking keeps every bit of redirect_pc in use while clearing the low two.
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  assign ibus_req  = (state != IDLE);
  assign ibus_addr = req_addr;

  // Flush is taken on the same edge as the redirect so stale entries never reach decode.
  assign fifo_flush = redirect_valid & ~rst;

  // A request is only launched when the queue has room and only one is ever
  // in flight, so this push cannot land on a full queue. Redirect suppresses
  // it, which also keeps push and flush mutually exclusive.
  assign fifo_push      = (state == REQ) & ibus_ack & ~redirect_valid & ~rst;
  assign fifo_push_data = {req_addr, ibus_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          // Any ack seen here belongs to an abandoned transaction and is ignored.
          if (redirect_valid) begin
            pc <= redirect_aligned;
          end else if (!fifo_full) begin
            req_addr <= pc;
            state    <= REQ;
          end
        end

        REQ: begin
          if (ibus_ack) begin
            pc    <= redirect_valid ? redirect_aligned : pc + XLEN'(4);
            state <= IDLE;
          end else if (redirect_valid) begin
            pc    <= redirect_aligned;
            state <= DISCARD;
          end
        end

        DISCARD: begin
          // The bus still owes us a response for req_addr; keep requesting
          // until it arrives, then drop it. Later redirects simply overwrite pc.
          if (redirect_valid) begin
            pc <= redirect_aligned;
          end
          if (ibus_ack) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: bus responder, depth-4 queue occupancy model and push scoreboard.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        fifo_full;
  logic        fifo_push;
  logic [63:0] fifo_push_data;
  logic        fifo_flush;

  inst_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ibus_req       (ibus_req),
    .ibus_addr      (ibus_addr),
    .ibus_ack       (ibus_ack),
    .ibus_rdata     (ibus_rdata),
    .fifo_full      (fifo_full),
    .fifo_push      (fifo_push),
    .fifo_push_data (fifo_push_data),
    .fifo_flush     (fifo_flush)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int push_cnt = 0;
  int exp_pushes = 0;
  fetch_entry_t sb_q[$];
  logic [31:0] exp_pc;

  // Queue occupancy model: depth 4, optional one-per-cycle drain by decode.
  logic [2:0] occ;
  logic       drain;
  assign fifo_full = (occ == 3'd4);
  always @(posedge clk) begin
    if (rst || fifo_flush) occ <= 3'd0;
    else occ <= occ + {2'b00, fifo_push} - {2'b00, (drain && occ != 3'd0)};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("push_and_flush", {63'd0, fifo_push & fifo_flush}, 64'd0);
      if (fifo_push) begin
        push_cnt++;
        check("push_while_full", {63'd0, fifo_full}, 64'd0);
        if (sb_q.size() == 0) check("unexpected_push", fifo_push_data, 64'd0 - 64'd1);
        else check("push_data", fifo_push_data, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!ibus_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {63'd0, ibus_req}, 64'd1);
  endtask

  // One read: wait for the request, check its address, stall, then ack.
  task automatic fetch(input int stall, input logic [31:0] data, output int lat);
    fetch_entry_t e;
    wait_req(lat);
    check("req_addr", {32'd0, ibus_addr}, {32'd0, exp_pc});
    for (int i = 0; i < stall; i++) begin
      ibus_ack = 1'b0;
      tick();
      check("stall_req", {63'd0, ibus_req}, 64'd1);
      check("stall_addr", {32'd0, ibus_addr}, {32'd0, exp_pc});
    end
    ibus_ack   = 1'b1;
    ibus_rdata = data;
    e.pc   = exp_pc;
    e.inst = data;
    sb_q.push_back(e);
    exp_pushes++;
    tick();
    ibus_ack = 1'b0;
    exp_pc   = exp_pc + 32'd4;
  endtask

  // Assert a redirect for one cycle and confirm the combinational flush.
  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    check("flush_on", {63'd0, fifo_flush}, 64'd1);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("flush_off", {63'd0, fifo_flush}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ibus_ack = 1'b0; ibus_rdata = '0; drain = 1'b0;
    exp_pc = RST_PC;

    // Reset state
    tick(); tick();
    check("rst_req", {63'd0, ibus_req}, 64'd0);
    check("rst_addr", {32'd0, ibus_addr}, {32'd0, RST_PC});
    check("rst_push", {63'd0, fifo_push}, 64'd0);
    check("rst_flush", {63'd0, fifo_flush}, 64'd0);
    rst = 1'b0;

    // Zero-wait stream: one request per 2 cycles, first right after reset.
    for (int i = 0; i < 4; i++) begin
      fetch(0, 32'h0000_0013, lat);
      check("zero_wait_gap", 64'(lat), 64'd1);
    end

    // Queue full: no requests, pc parked at 0x80000010.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_req", {63'd0, ibus_req}, 64'd0);
    end
    drain = 1'b1;
    fetch(0, 32'h0000_0093, lat);
    check("after_full_pc", {32'd0, exp_pc}, 64'h8000_0014);

    // Delayed ack: request held stable, exactly one push.
    fetch(3, 32'hCAFE_0001, lat);

    // Redirect while waiting, ack two cycles later is dropped.
    wait_req(lat);
    redirect(32'h8000_0103);
    check("discard_req", {63'd0, ibus_req}, 64'd1);
    check("discard_addr", {32'd0, ibus_addr}, {32'd0, exp_pc});
    tick();
    ibus_ack = 1'b1; ibus_rdata = 32'hBAD0_BAD0;
    tick();
    ibus_ack = 1'b0;
    exp_pc = 32'h8000_0100;
    fetch(0, 32'h1111_0001, lat);

    // Redirect coinciding with ack: no push.
    wait_req(lat);
    ibus_ack = 1'b1; ibus_rdata = 32'hBAD1_BAD1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    #1;
    check("ack_redir_flush", {63'd0, fifo_flush}, 64'd1);
    check("ack_redir_push", {63'd0, fifo_push}, 64'd0);
    tick();
    ibus_ack = 1'b0; redirect_valid = 1'b0;
    exp_pc = 32'h8000_0200;
    fetch(0, 32'h2222_0002, lat);

    // Two redirects while discarding: the last one wins.
    wait_req(lat);
    redirect(32'h8000_0300);
    redirect(32'h8000_0402);
    check("discard2_req", {63'd0, ibus_req}, 64'd1);
    ibus_ack = 1'b1;
    tick();
    ibus_ack = 1'b0;
    exp_pc = 32'h8000_0400;
    fetch(0, 32'h3333_0003, lat);

    // Redirect taken in IDLE, then pc wraps past the top of the address space.
    redirect(32'hFFFF_FFFC);
    exp_pc = 32'hFFFF_FFFC;
    fetch(0, 32'h4444_0004, lat);
    fetch(0, 32'h5555_0005, lat);
    check("wrap_pc", {32'd0, exp_pc}, 64'h0000_0004);

    // Reset while in REQ abandons the read; a late ack in IDLE is ignored.
    wait_req(lat);
    rst = 1'b1;
    tick();
    check("rst_mid_req", {63'd0, ibus_req}, 64'd0);
    check("rst_mid_addr", {32'd0, ibus_addr}, {32'd0, RST_PC});
    rst = 1'b0;
    ibus_ack = 1'b1; ibus_rdata = 32'hBAD2_BAD2;
    tick();
    ibus_ack = 1'b0;
    exp_pc = RST_PC;
    fetch(0, 32'h6666_0006, lat);
    fetch(0, 32'h7777_0007, lat);

    tick(); tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("push_count", 64'(push_cnt), 64'(exp_pushes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Front-end fetch stage. Generates sequential PCs, issues single-outstanding reads on the instruction bus, and pushes {pc, inst} entries into the instruction-queue SyncFIFO (DEPTH 4, LINE_WIDTH 64) that feeds decode. Handles redirects from branch/exception logic by flushing the queue and discarding any in-flight response.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; bits [1:0] must be 0
XLEN, 32, PC and instruction width; entry width is 2*XLEN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirect_valid  in  1  redirect request from branch/exception unit
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and treated as 0
ibus_req  out  1  read request; held until ibus_ack
ibus_addr  out  XLEN  read address; stable while ibus_req is high
ibus_ack  in  1  one-cycle response strobe; ibus_rdata is valid in the same cycle
ibus_rdata  in  XLEN  instruction word
fifo_full  in  1  instruction queue full
fifo_push  out  1  push strobe to the queue
fifo_push_data  out  2*XLEN  {pc[XLEN-1:0], inst[XLEN-1:0]}, pc in the upper half
fifo_flush  out  1  flush to the queue

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pc=RESET_PC, ibus_req=0, fifo_push=0, fifo_flush=0, ibus_addr=RESET_PC.
- rst has priority over all inputs. A reset mid-transaction abandons the transaction; an ibus_ack seen in IDLE is ignored.
- State register. Three states: IDLE, REQ, DISCARD.
- Output decoding:
  - ibus_req = (state != IDLE).
  - ibus_addr = the registered request address, captured when entering REQ.
- fifo_flush = redirect_valid & ~rst, combinational. The queue therefore clears on the same edge the redirect is taken.
- IDLE transitions:
  - redirect_valid: pc <= {redirect_pc[XLEN-1:2], 2'b00}; stay in IDLE.
  - else if ~fifo_full: req_addr <= pc; go to REQ.
  - else: stay in IDLE.
- REQ transitions:
  - ibus_ack & ~redirect_valid: fifo_push=1 with {req_addr, ibus_rdata}; pc <= pc+4 (wraps modulo 2^XLEN); go to IDLE.
  - ibus_ack & redirect_valid: no push; pc <= redirect_pc (aligned); go to IDLE.
  - ~ibus_ack & redirect_valid: pc <= redirect_pc (aligned); go to DISCARD.
  - otherwise: hold.
- DISCARD transitions:
  - ibus_req stays high with the old address, as the bus protocol requires.
  - ibus_ack: drop the data, never push; go to IDLE.
  - A further redirect_valid updates pc (last redirect wins), re-asserts fifo_flush, and stays in DISCARD.
- Push safety: a request is issued only when ~fifo_full, at most one is outstanding, and this unit is the queue's only writer. The push on ack can never see a full queue. fifo_push is never asserted while fifo_full.
- fifo_push and fifo_flush are never both high in the same cycle.
- Latency: IDLE->REQ takes 1 cycle. With zero-wait ack, throughput is 1 entry per 2 cycles. The first request after reset appears on the cycle after rst deasserts.

Decomposition:
- fetch_pkg holds:
  - fetch_state_e {IDLE, REQ, DISCARD}
  - fetch_entry_t packed struct {pc, inst}
  - FETCH_ENTRY_WIDTH = 2*XLEN
  - RESET_PC default
- The SyncFIFO instantiation uses LINE_WIDTH = FETCH_ENTRY_WIDTH.
- No sub-module: a single state machine plus the pc/req_addr registers.

Test Plan:
- Reset then zero-wait ack returning 0x00000013 for each read -> pushes {0x80000000,0x00000013}, {0x80000004,0x00000013}, ... one push every 2 cycles; ibus_addr increments by 4.
- Hold fifo_full=1 after 4 pushes -> ibus_req stays 0 and pc holds at 0x80000010. Release fifo_full -> next request addr is 0x80000010.
- Ack delayed 3 cycles -> ibus_req and ibus_addr stay stable for all 3 cycles; exactly one push follows.
- In REQ, redirect to 0x80000103 without ack, then ack 2 cycles later -> fifo_flush pulses 1 cycle; the ack data is not pushed; the next request addr is 0x80000100.
- Redirect to 0x80000200 in the same cycle as ack -> no push, fifo_flush=1, the next request addr is 0x80000200.
- rst asserted while in REQ -> next cycle state=IDLE and ibus_req=0. A late ack is ignored and pc=RESET_PC.
